// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared constants and ratio/high-time clamp helpers for freq_divider_prog
package freq_div_pkg;
  localparam int DIV_MIN = 2;
  localparam int DIV_DEFAULT = 50_000_000;
  localparam int FN_W = 32;
  function automatic logic [FN_W-1:0] clamp_n(input logic [FN_W-1:0] n);
    return n < FN_W'(DIV_MIN) ? FN_W'(DIV_MIN) : n;
  endfunction
  function automatic logic [FN_W-1:0] clamp_h(input logic [FN_W-1:0] h, input logic [FN_W-1:0] n);
    return h == '0 ? FN_W'(1) : h >= n ? n - FN_W'(1) : h;
  endfunction
endpackage

// File: rtl/freq_div_shadow.sv
// freq_div_shadow: shadow ratio/duty regs, pending flag, clamping and wrap bypass (duty_in only with FREQ_DIV_DUTY_EN)
module freq_div_shadow
  import freq_div_pkg::*;
#(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wrap,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
`ifdef FREQ_DIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_in,
`endif
  output logic             div_pending,
  output logic             apply,
  output logic [CNT_W-1:0] n_new,
  output logic [CNT_W-1:0] h_new
);
  logic [CNT_W-1:0] n_sh, h_sh, n_ld, h_ld;
  always_comb begin
    n_ld = CNT_W'(clamp_n(FN_W'(div_in)));
`ifdef FREQ_DIV_DUTY_EN
    h_ld = CNT_W'(clamp_h(FN_W'(duty_in), FN_W'(n_ld)));
`else
    h_ld = n_ld >> 1;
`endif
    apply = wrap ? (div_pending | div_load) : (!en && div_pending);
    n_new = div_load ? n_ld : n_sh;
    h_new = div_load ? h_ld : h_sh;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      n_sh        <= '0;
      h_sh        <= '0;
      div_pending <= 1'b0;
    end else begin
      if (div_load) begin
        n_sh <= n_ld;
        h_sh <= h_ld;
      end
      div_pending <= (div_pending | div_load) & !apply;
    end
  end
endmodule

// File: rtl/freq_divider_prog.sv
// freq_divider_prog: programmable clock-enable divider with boundary-aligned reload; FREQ_DIV_DUTY_EN adds duty_in
module freq_divider_prog
  import freq_div_pkg::*;
#(
  parameter int CNT_W     = 26,
  parameter int DIV_RESET = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
`ifdef FREQ_DIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_in,
`endif
  output logic             div_pending,
  output logic             div_ack,
  output logic             q,
  output logic             tick
);
  logic [CNT_W-1:0] cnt, n_act, h_act, cnt_n, n_n, h_n, n_new, h_new;
  logic wrap, apply;
  always_comb wrap = en && cnt == n_act - CNT_W'(1);
  always_comb begin
    cnt_n = (apply || wrap) ? '0 : en ? cnt + CNT_W'(1) : cnt;
    n_n   = apply ? n_new : n_act;
    h_n   = apply ? h_new : h_act;
  end
  freq_div_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .wrap        (wrap),
    .div_load    (div_load),
    .div_in      (div_in),
`ifdef FREQ_DIV_DUTY_EN
    .duty_in     (duty_in),
`endif
    .div_pending (div_pending),
    .apply       (apply),
    .n_new       (n_new),
    .h_new       (h_new)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      n_act   <= CNT_W'(DIV_RESET);
      h_act   <= CNT_W'(DIV_RESET >> 1);
      q       <= 1'b0;
      tick    <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      n_act   <= n_n;
      h_act   <= h_n;
      q       <= cnt_n >= n_n - h_n;
      tick    <= wrap;
      div_ack <= apply;
    end
  end
endmodule

// File: tb/tb_freq_divider_prog.sv
// tb_freq_divider_prog: scoreboard bench for freq_divider_prog (CNT_W=8, DIV_RESET=10); duty cases with FREQ_DIV_DUTY_EN
module tb_freq_divider_prog;
  localparam int CNT_W = 8;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, div_load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
`ifdef FREQ_DIV_DUTY_EN
  logic [CNT_W-1:0] duty_in = '0;
`endif
  logic div_pending, div_ack, q, tick;
  int n_cmp = 0, n_err = 0, ecyc = 0, t, acks;
  int exp_q[$];
  freq_divider_prog #(.CNT_W(CNT_W), .DIV_RESET(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .div_in      (div_in),
    .div_load    (div_load),
`ifdef FREQ_DIV_DUTY_EN
    .duty_in     (duty_in),
`endif
    .div_pending (div_pending),
    .div_ack     (div_ack),
    .q           (q),
    .tick        (tick)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ecyc <= ecyc + 1;
  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, ecyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) chk("tick_extra", ecyc, -1);
      else chk("tick_at", ecyc, exp_q.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    step(2);
    chk("rst_q", int'(q), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pend", int'(div_pending), 0);
    chk("rst_ack", int'(div_ack), 0);
    reset = 1'b0;
    en = 1'b1;
    t = ecyc;
    exp_q.push_back(t + 10);
    exp_q.push_back(t + 20);
    exp_q.push_back(t + 30);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("q_div10", int'(q), int'((k % 10) >= 5));
    end
    step(3);
    t = ecyc;
    div_in = 8'd7;
    div_load = 1'b1;
    exp_q.push_back(t + 7);
    exp_q.push_back(t + 14);
    exp_q.push_back(t + 21);
    step();
    div_load = 1'b0;
    chk("pend_set", int'(div_pending), 1);
    step(5);
    chk("pend_hold", int'(div_pending), 1);
    chk("ack_early", int'(div_ack), 0);
    step();
    chk("ack_n7", int'(div_ack), 1);
    chk("pend_clr", int'(div_pending), 0);
    chk("q_wrap", int'(q), 0);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("q_div7", int'(q), int'((k % 7) >= 4));
      if (k == 1) chk("ack_pulse", int'(div_ack), 0);
    end
    t = ecyc;
    div_in = 8'd0;
    div_load = 1'b1;
    exp_q.push_back(t + 7);
    step();
    div_load = 1'b0;
    step(6);
    chk("ack_n0", int'(div_ack), 1);
    t = ecyc;
    div_in = 8'd1;
    div_load = 1'b1;
    exp_q.push_back(t + 2);
    exp_q.push_back(t + 4);
    exp_q.push_back(t + 6);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) div_load = 1'b0;
      chk("q_div2", int'(q), k % 2);
      if (k == 2) chk("ack_n1", int'(div_ack), 1);
    end
    step();
    t = ecyc;
    div_in = 8'd5;
    div_load = 1'b1;
    exp_q.push_back(t + 1);
    exp_q.push_back(t + 6);
    step();
    div_load = 1'b0;
    chk("pend_bypass", int'(div_pending), 0);
    chk("ack_bypass", int'(div_ack), 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("q_div5", int'(q), int'((k % 5) >= 3));
    end
    t = ecyc;
    acks = 0;
    div_in = 8'd3;
    div_load = 1'b1;
    exp_q.push_back(t + 5);
    exp_q.push_back(t + 9);
    exp_q.push_back(t + 13);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 1) div_in = 8'd4;
      if (k == 2) div_load = 1'b0;
      acks += int'(div_ack);
      if (k > 5) chk("q_div4", int'(q), int'(((k - 5) % 4) >= 2));
    end
    chk("ack_once", acks, 1);
    step(2);
    chk("q_pre_freeze", int'(q), 1);
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("q_frozen", int'(q), 1);
      chk("tick_frozen", int'(tick), 0);
    end
    en = 1'b1;
    exp_q.push_back(ecyc + 2);
    step();
    chk("q_resume", int'(q), 1);
    step();
    chk("q_resume_wrap", int'(q), 0);
    step(3);
    en = 1'b0;
    div_in = 8'd6;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("pend_dis", int'(div_pending), 1);
    chk("q_dis_hold", int'(q), 1);
    step();
    chk("ack_dis", int'(div_ack), 1);
    chk("pend_dis_clr", int'(div_pending), 0);
    chk("q_dis_clr", int'(q), 0);
    en = 1'b1;
    t = ecyc;
    exp_q.push_back(t + 6);
    exp_q.push_back(t + 12);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("q_div6", int'(q), int'((k % 6) >= 3));
    end
    div_in = 8'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("pend_pre_rst", int'(div_pending), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("pend_rst", int'(div_pending), 0);
    chk("q_rst", int'(q), 0);
    chk("ack_rst", int'(div_ack), 0);
    t = ecyc;
    exp_q.push_back(t + 10);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("q_div10_rst", int'(q), int'((k % 10) >= 5));
    end
`ifdef FREQ_DIV_DUTY_EN
    en = 1'b0;
    div_in = 8'd8;
    duty_in = 8'd0;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    en = 1'b1;
    t = ecyc;
    exp_q.push_back(t + 8);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("q_h1", int'(q), int'((k % 8) >= 7));
    end
    en = 1'b0;
    duty_in = 8'd9;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    en = 1'b1;
    t = ecyc;
    exp_q.push_back(t + 8);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("q_h7", int'(q), int'((k % 8) >= 1));
    end
`endif
    step(3);
    chk("tick_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
